seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display sharing one BCD decoder.
// Values load through valid/ready into a shadow register and are committed only at frame boundaries.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              blank_lz,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_value,
  output logic [3:0]        bcd_out,
  output logic              bcd_en,
  output logic [NDIG-1:0]   dig_sel
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*NDIG-1:0]   active, active_n, shadow, shadow_n;
  logic                pending, pending_n;
  logic                tick, last, commit, xfer;

  logic [NDIG-1:0][3:0] act_n;
  logic                 up_zero, lz_n;
  logic [NDIG-1:0]      dig_sel_n;
  logic [3:0]           bcd_out_n;
  logic                 bcd_en_n;

  assign tick   = (cnt == CW'(DIV - 1));
  assign last   = (idx == IW'(NDIG - 1));
  // Commit needs pending=1, so load_ready is already low: commit and transfer never coincide.
  assign commit = tick && (state == SHOW) && last && pending;
  assign xfer   = load_valid && load_ready;
  assign cnt_n  = tick ? '0 : cnt + 1'b1;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;
    if (state == BLANK) begin
      state_n = SHOW;
    end else if (tick) begin
      state_n = BLANK;
      idx_n   = last ? '0 : idx + 1'b1;
    end
    if (commit) begin
      active_n  = shadow;
      pending_n = 1'b0;
    end else if (xfer) begin
      shadow_n  = load_value;
      pending_n = 1'b1;
    end
  end

  // Outputs are derived from next-state values so the registered outputs track the state.
  assign act_n = active_n;

  always_comb begin
    up_zero = 1'b1;
    for (int i = 0; i < NDIG; i++)
      if ((i >= int'(idx_n)) && (act_n[i] != 4'd0)) up_zero = 1'b0;
    lz_n = blank_lz && (idx_n != '0) && up_zero;
  end

  always_comb begin
    dig_sel_n = '1;
    bcd_out_n = 4'd0;
    bcd_en_n  = 1'b0;
    if (state_n == SHOW) begin
      dig_sel_n = en ? ~(NDIG'(1) << idx_n) : '1;
      bcd_out_n = act_n[idx_n];
      bcd_en_n  = en && !lz_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      dig_sel    <= '1;
      bcd_out    <= 4'd0;
      bcd_en     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      active     <= active_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      load_ready <= ~pending_n;
      dig_sel    <= dig_sel_n;
      bcd_out    <= bcd_out_n;
      bcd_en     <= bcd_en_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4, DIV=4): a per-edge vector table plus reset sequences.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, blank_lz, load_valid, load_ready, bcd_en;
  logic [15:0] load_value;
  logic [3:0]  bcd_out, dig_sel;

  int checks = 0;
  int errors = 0;
  int kcyc   = 0;

  seg_scan_ctrl #(.NDIG(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .bcd_out(bcd_out), .bcd_en(bcd_en), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  // Row: inputs held from the previous sample up to edge cyc, outputs checked after edge cyc.
  typedef struct {
    int          cyc;
    logic        en;
    logic        blz;
    logic        lv;
    logic [15:0] val;
    logic [3:0]  sel;
    logic [3:0]  bcd;
    logic        ben;
    logic        rdy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int c, input logic e, input logic z, input logic v, input logic [15:0] d,
                     input logic [3:0] s, input logic [3:0] b, input logic be, input logic r);
    vec_t t;
    t.cyc = c; t.en = e; t.blz = z; t.lv = v; t.val = d;
    t.sel = s; t.bcd = b; t.ben = be; t.rdy = r;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [3:0] s, input logic [3:0] b,
                     input logic be, input logic r);
    checks++;
    if ({dig_sel, bcd_out, bcd_en, load_ready} !== {s, b, be, r}) begin
      errors++;
      $display("FAIL %s: got sel=%b bcd=%h en=%b rdy=%b, want sel=%b bcd=%h en=%b rdy=%b",
               nm, dig_sel, bcd_out, bcd_en, load_ready, s, b, be, r);
    end
  endtask

  task automatic step_to(input int target);
    if (target <= kcyc) begin
      checks++;
      errors++;
      $display("FAIL step_to: target %0d not after cycle %0d", target, kcyc);
    end
    while (kcyc < target) begin
      @(posedge clk);
      kcyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; blank_lz = 1'b0; load_valid = 1'b0; load_value = 16'h0;

    //   cyc  en blz lv  value     sel      bcd ben rdy
    add(  1, 1, 0, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);   // first SHOW, 1 cycle after release
    add(  3, 1, 0, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);
    add(  4, 1, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);   // dead time
    add(  5, 1, 0, 0, 16'h0000, 4'b1101, 4'h0, 1, 1);
    add(  8, 1, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add(  9, 1, 0, 0, 16'h0000, 4'b1011, 4'h0, 1, 1);
    add( 13, 1, 0, 0, 16'h0000, 4'b0111, 4'h0, 1, 1);
    add( 16, 1, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add( 17, 1, 0, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);   // frame = 16 cycles
    add( 18, 1, 0, 1, 16'h1234, 4'b1110, 4'h0, 1, 0);   // accepted mid-frame
    add( 19, 1, 0, 1, 16'h5678, 4'b1110, 4'h0, 1, 0);   // held while pending
    add( 21, 1, 0, 1, 16'h5678, 4'b1101, 4'h0, 1, 0);   // old value still shown
    add( 31, 1, 0, 1, 16'h5678, 4'b0111, 4'h0, 1, 0);
    add( 32, 1, 0, 1, 16'h5678, 4'b1111, 4'h0, 0, 1);   // commit edge, no transfer
    add( 33, 1, 0, 1, 16'h5678, 4'b1110, 4'h4, 1, 0);   // 1234 visible, 5678 taken
    add( 34, 1, 0, 0, 16'h0000, 4'b1110, 4'h4, 1, 0);
    add( 37, 1, 0, 0, 16'h0000, 4'b1101, 4'h3, 1, 0);
    add( 41, 1, 0, 0, 16'h0000, 4'b1011, 4'h2, 1, 0);
    add( 45, 1, 0, 0, 16'h0000, 4'b0111, 4'h1, 1, 0);
    add( 47, 1, 0, 0, 16'h0000, 4'b0111, 4'h1, 1, 0);
    add( 48, 1, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add( 49, 1, 0, 0, 16'h0000, 4'b1110, 4'h8, 1, 1);
    add( 53, 1, 0, 0, 16'h0000, 4'b1101, 4'h7, 1, 1);
    add( 57, 1, 0, 0, 16'h0000, 4'b1011, 4'h6, 1, 1);
    add( 61, 1, 0, 0, 16'h0000, 4'b0111, 4'h5, 1, 1);
    add( 62, 1, 1, 1, 16'h0070, 4'b0111, 4'h5, 1, 0);   // blanking uses active, not shadow
    add( 63, 1, 1, 0, 16'h0000, 4'b0111, 4'h5, 1, 0);
    add( 64, 1, 1, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add( 65, 1, 1, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);
    add( 69, 1, 1, 0, 16'h0000, 4'b1101, 4'h7, 1, 1);
    add( 73, 1, 1, 0, 16'h0000, 4'b1011, 4'h0, 0, 1);   // leading zero blanked, select kept
    add( 77, 1, 1, 0, 16'h0000, 4'b0111, 4'h0, 0, 1);
    add( 78, 1, 1, 1, 16'h0000, 4'b0111, 4'h0, 0, 0);
    add( 79, 1, 1, 0, 16'h0000, 4'b0111, 4'h0, 0, 0);
    add( 80, 1, 1, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add( 81, 1, 1, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);   // digit 0 never blanked
    add( 85, 1, 1, 0, 16'h0000, 4'b1101, 4'h0, 0, 1);
    add( 89, 1, 1, 0, 16'h0000, 4'b1011, 4'h0, 0, 1);
    add( 93, 1, 1, 0, 16'h0000, 4'b0111, 4'h0, 0, 1);
    add( 95, 1, 0, 0, 16'h0000, 4'b0111, 4'h0, 1, 1);
    add( 97, 1, 0, 0, 16'h0000, 4'b1110, 4'h0, 1, 1);
    add( 98, 0, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);   // en low for edges 98..107
    add(101, 0, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add(104, 0, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add(107, 0, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add(108, 1, 0, 0, 16'h0000, 4'b1111, 4'h0, 0, 1);
    add(109, 1, 0, 0, 16'h0000, 4'b0111, 4'h0, 1, 1);   // scan kept its position
    add(110, 1, 0, 1, 16'h9999, 4'b0111, 4'h0, 1, 0);   // leaves a load pending

    #2 chk("reset_t0", 4'b1111, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset_held", 4'b1111, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    kcyc = 0;

    foreach (tv[i]) begin
      en = tv[i].en; blank_lz = tv[i].blz; load_valid = tv[i].lv; load_value = tv[i].val;
      step_to(tv[i].cyc);
      chk($sformatf("vec%0d_cyc%0d", i, tv[i].cyc), tv[i].sel, tv[i].bcd, tv[i].ben, tv[i].rdy);
    end

    // Asynchronous reset in the middle of a SHOW cycle with a pending load.
    load_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async", 4'b1111, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_async_held", 4'b1111, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    kcyc = 0;
    step_to(1);  chk("post_rst_c1",  4'b1110, 4'h0, 1'b1, 1'b1);
    step_to(17); chk("post_rst_c17", 4'b1110, 4'h0, 1'b1, 1'b1);
    step_to(29); chk("post_rst_c29", 4'b0111, 4'h0, 1'b1, 1'b1);
    step_to(33); chk("post_rst_c33", 4'b1110, 4'h0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
